// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings for the USB endpoint register path.
// Transfer type, burst and size codes plus the handshake state constants.
package ahb_lite_master_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;

   localparam logic [1:0] HSIZE_BYTE = 2'd0;
   localparam logic [1:0] HSIZE_HALF = 2'd1;
   localparam logic [1:0] HSIZE_WORD = 2'd2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACK  = 2'd1;
   localparam logic [1:0] ST_NACK = 2'd2;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite SINGLE-transfer initiator: one address slot pipelined over one data slot,
// with wait-state absorption and re-issue of the held command after an ERROR response.
module ahb_lite_master
   import ahb_lite_master_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [1:0]            cmd_size,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic                  hsel,
   output logic [ADDR_WIDTH-1:0] haddr,
   output logic [1:0]            htrans,
   output logic [2:0]            hburst,
   output logic [1:0]            hsize,
   output logic                  hwrite,
   output logic [DATA_WIDTH-1:0] hwdata,
   input  logic [DATA_WIDTH-1:0] hrdata,
   input  logic                  hresp,
   input  logic                  hready
);

   logic                  a_valid, a_live;
   logic                  d_valid, d_write;
   logic [DATA_WIDTH-1:0] a_wdata;
   logic                  accept, a_done, d_done, err_first, a_valid_nxt;

   // a_valid && !a_live: command parked during an ERROR, bus shows IDLE
   assign cmd_ready   = !a_valid || (a_live && hready);
   assign accept      = cmd_valid && cmd_ready;
   assign a_done      = a_live && hready;
   assign d_done      = d_valid && hready;
   assign err_first   = d_valid && hresp && !hready;
   assign a_valid_nxt = accept || (a_valid && !a_done);

   assign htrans = a_live ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign hsel   = a_live;
   assign hburst = HBURST_SINGLE;

   // Address slot; the bus address-phase registers double as its payload
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         a_valid <= 1'b0;
         a_live  <= 1'b0;
         haddr   <= '0;
         hsize   <= '0;
         hwrite  <= 1'b0;
         a_wdata <= '0;
      end else begin
         a_valid <= a_valid_nxt;
         a_live  <= a_valid_nxt && !err_first;
         if (accept) begin
            haddr   <= cmd_addr;
            hsize   <= cmd_size;
            hwrite  <= cmd_write;
            a_wdata <= cmd_wdata;
         end
      end
   end

   // Data slot; hwdata only moves when an address phase hands over
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         d_valid <= 1'b0;
         d_write <= 1'b0;
         hwdata  <= '0;
      end else begin
         d_valid <= a_done || (d_valid && !d_done);
         if (a_done) begin
            d_write <= hwrite;
            if (hwrite) hwdata <= a_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
      end else begin
         rsp_valid <= d_done;
         if (d_done) begin
            rsp_error <= hresp;
            rsp_rdata <= d_write ? '0 : hrdata;
         end
      end
   end

endmodule
